gbemac_tx_packetizer: RTL and testbench
=======================================

Name: gbemac_tx_packetizer

Overview:
- Upstream neighbour of the TEMAC TX user interface, in the Clk_user domain.
- Takes a continuous 32-bit sample stream (no framing) and produces framed AXI-Stream packets.
- Each packet is HDR_WORDS programmable header words, then packetSize payload words, with tlast on the final word.
- Its m_axis output drives the MAC wrapper's s_axis slave port directly.

Parameters:
- HDR_WORDS, 11, number of 32-bit header words emitted before each payload; range 1..16.
- HDR_AW, 4, header RAM address width; must satisfy 2^HDR_AW >= HDR_WORDS.

Ports:
- Clk_user  input  1  user clock; all logic is on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- enable  input  1  allows new frames to start.
- packetSize  input  16  payload words per frame; sampled at frame start.
- hdrWrEn  input  1  header register write strobe.
- hdrAddr  input  HDR_AW  header word index.
- hdrData  input  32  header word value.
- s_axis_tvalid  input  1  sample valid.
- s_axis_tready  output  1  sample accepted.
- s_axis_tdata  input  32  sample data.
- m_axis_tvalid  output  1  framed word valid.
- m_axis_tready  input  1  downstream ready; this is the MAC wrapper's s_axis_tready.
- m_axis_tdata  output  32  framed word.
- m_axis_tlast  output  1  last word of frame.
- busy  output  1  high in any state other than IDLE.
- frameCount  output  32  count of completed frames; wraps at 2^32.

Behaviour:
- Reset (async assert, sync release to Clk_user):
  - state=IDLE; outputs m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, busy=0, frameCount=0.
  - Header RAM contents are not reset.
- Output register: single stage. It loads when it is empty or (m_axis_tvalid && m_axis_tready). m_axis_tdata and m_axis_tlast stay stable while tvalid=1 and tready=0.
- Handshake rule: the register is full when m_axis_tvalid=1; an advance occurs on any cycle where the register loads.
- s_axis_tready = (state==PAYLOAD) && (register empty or m_axis_tready). It is combinational from m_axis_tready, with no combinational path from s_axis_tvalid.
- Latency: an accepted sample appears on m_axis_tdata on the next cycle.
- IDLE -> HDR when enable && s_axis_tvalid:
  - latch pktLen = (packetSize==0) ? 1 : packetSize;
  - clear word counter.
  - No frame starts without pending data.
- HDR: on each advance, load hdr[cnt] with tlast=0, then cnt++.
  - After word HDR_WORDS-1 the block moves to SEQ if the option is compiled in, otherwise to PAYLOAD; cnt is cleared.
- PAYLOAD: on each s_axis handshake, load s_axis_tdata and set tlast=(cnt==pktLen-1), then cnt++.
  - On the last word go to IDLE and increment frameCount.
  - Deasserting s_axis_tvalid mid-payload stalls the block (bubbles allowed); the frame is never truncated.
- enable low mid-frame: the current frame completes and no new frame starts. enable is checked only in IDLE.
- packetSize changes mid-frame are ignored; they apply to the next frame.
- Header writes are accepted in any state, one word per cycle.
  - A write to the word being loaded in the same cycle: the old value is emitted.
  - Software writes only while busy=0. Writes to addresses >= HDR_WORDS are ignored.
- Back-to-back frames: IDLE is one cycle, so there is one bubble between frames. The tlast word may still be held in the register while the next frame starts.
- Counters: cnt is 16 bits, large enough for pktLen up to 65535; the header index uses the low HDR_AW bits.
- Reset mid-frame aborts immediately: tvalid drops asynchronously and the partial frame is not completed.

Optional Feature:
- Macro: GBEMAC_PKT_SEQNUM_EN.
- Defined:
  - A SEQ state between HDR and PAYLOAD emits one word carrying a 32-bit sequence number, tlast=0.
  - The sequence number starts at 0 after reset and increments when that word advances; it wraps modulo 2^32.
  - Frame length becomes HDR_WORDS+1+pktLen.
- Undefined: there is no SEQ state and frame length is HDR_WORDS+pktLen.

Decomposition:
- Shared package gbemac_pkg holds:
  - the state enum {IDLE, HDR, SEQ, PAYLOAD};
  - the constant AXIS_DW=32;
  - the default HDR_WORDS;
  - the packetSize-zero clamp constant.
- Sub-module gbemac_hdr_ram: HDR_WORDS x 32 register file with a synchronous write port and an asynchronous read port, indexed by cnt.
- The FSM and the output register stay in the top module.

Test Plan:
- Build without the macro. HDR_WORDS=11, header words = 0xA0..0xAA, packetSize=4, samples 1..8 continuous, m_axis_tready=1 -> two frames of 15 words each (0xA0..0xAA, then 1,2,3,4 / 5,6,7,8); tlast on words 15 and 30; frameCount=2.
- Toggle m_axis_tready as 1,0,0,1 repeating -> the same word sequence with no loss or duplication; tdata stable while stalled.
- Set packetSize=0 -> each frame carries 1 payload word with tlast on it; change packetSize 4->2 mid-frame -> the current frame keeps 4 payload words and the next frame has 2.
- Drop enable during word 5 of a frame -> that frame completes; busy falls; s_axis_tready stays 0 afterwards.
- Pulse Reset for 1 cycle mid-payload -> m_axis_tvalid=0 immediately; frameCount=0; with s_axis_tvalid held, the next frame restarts from header word 0xA0.
- Build with GBEMAC_PKT_SEQNUM_EN, packetSize=2, three frames -> word 12 of each frame is 0, 1, 2 respectively; frame length is 14.

Source files
------------

// File: rtl/gbemac_pkg.sv
// Shared types and constants for the GbE MAC TX packetizer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gbemac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    SEQ     = 2'd2,
    PAYLOAD = 2'd3
  } gbemac_state_e;

  localparam int AXIS_DW           = 32;
  localparam int HDR_WORDS_DEFAULT = 11;

  // A zero packetSize still carries one payload word so tlast always has a home.
  localparam logic [15:0] PKT_LEN_MIN = 16'd1;

  function automatic logic [15:0] clamp_pkt_len(input logic [15:0] size);
    return (size == 16'd0) ? PKT_LEN_MIN : size;
  endfunction

endpackage

// File: rtl/gbemac_hdr_ram.sv
// Header word register file: HDR_WORDS x 32, sync write, async read.
// Latency: write visible on the cycle after wr_en; read is combinational.
// Backpressure: none; a write and a read of the same word in one cycle returns the old value.
//
// Ports:
//   Clk_user          write clock
//   wr_en/wr_addr/wr_dat  write port; addresses >= HDR_WORDS are dropped
//   rd_addr/rd_dat        read port, indexed by the packetizer word counter
module gbemac_hdr_ram
  import gbemac_pkg::*;
#(
  parameter int HDR_WORDS = HDR_WORDS_DEFAULT,
  parameter int HDR_AW    = 4
) (
  input  logic                 Clk_user,
  input  logic                 wr_en,
  input  logic [HDR_AW-1:0]    wr_addr,
  input  logic [AXIS_DW-1:0]   wr_dat,
  input  logic [HDR_AW-1:0]    rd_addr,
  output logic [AXIS_DW-1:0]   rd_dat
);

  // Contents are deliberately not reset: software reloads headers after boot.
  logic [AXIS_DW-1:0] mem [HDR_WORDS];

  always_ff @(posedge Clk_user) begin
    if (wr_en && (int'(wr_addr) < HDR_WORDS)) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = (int'(rd_addr) < HDR_WORDS) ? mem[rd_addr] : '0;

endmodule

// File: rtl/gbemac_tx_packetizer.sv
// Frames a continuous 32-bit sample stream into AXI-Stream packets: header words, [seq], payload.
// Latency: one cycle from an accepted sample (or header fetch) to m_axis_tdata.
// Backpressure: single output register; s_axis_tready follows m_axis_tready while in PAYLOAD.
//
// Ports:
//   Clk_user, Reset (async, active-high)
//   enable, packetSize         frame start gate and payload length (sampled at frame start)
//   hdrWrEn/hdrAddr/hdrData    header RAM write port
//   s_axis_*                   unframed sample input
//   m_axis_*                   framed output to the MAC wrapper s_axis port
//   busy, frameCount           status
// Build option: define GBEMAC_PKT_SEQNUM_EN to insert a 32-bit sequence word after the header.
module gbemac_tx_packetizer
  import gbemac_pkg::*;
#(
  parameter int HDR_WORDS = HDR_WORDS_DEFAULT,
  parameter int HDR_AW    = 4
) (
  input  logic                Clk_user,
  input  logic                Reset,
  input  logic                enable,
  input  logic [15:0]         packetSize,
  input  logic                hdrWrEn,
  input  logic [HDR_AW-1:0]   hdrAddr,
  input  logic [31:0]         hdrData,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [31:0]         s_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic [31:0]         frameCount
);

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_HDR     = 2'(HDR);
  localparam logic [1:0] ST_PAYLOAD = 2'(PAYLOAD);
`ifdef GBEMAC_PKT_SEQNUM_EN
  localparam logic [1:0] ST_SEQ     = 2'(SEQ);
`endif

  logic [1:0]          state;
  logic [15:0]         cnt;
  logic [15:0]         pkt_len;
  logic [AXIS_DW-1:0]  hdr_rd_dat;
  logic                reg_load;
  logic                s_hs;
  logic                hdr_last;
  logic                pay_last;
`ifdef GBEMAC_PKT_SEQNUM_EN
  logic [31:0]         seq_num;
`endif

  gbemac_hdr_ram #(
    .HDR_WORDS (HDR_WORDS),
    .HDR_AW    (HDR_AW)
  ) u_hdr_ram (
    .Clk_user (Clk_user),
    .wr_en    (hdrWrEn),
    .wr_addr  (hdrAddr),
    .wr_dat   (hdrData),
    .rd_addr  (cnt[HDR_AW-1:0]),
    .rd_dat   (hdr_rd_dat)
  );

  // The output register may take a new word when empty or being drained this cycle.
  assign reg_load      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_PAYLOAD) && reg_load;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign hdr_last      = (cnt == 16'(HDR_WORDS - 1));
  assign pay_last      = (cnt == (pkt_len - 16'd1));
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      pkt_len       <= PKT_LEN_MIN;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      frameCount    <= '0;
`ifdef GBEMAC_PKT_SEQNUM_EN
      seq_num       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // Lets a held tlast word drain while the next frame is being started.
          if (reg_load) begin
            m_axis_tvalid <= 1'b0;
          end
          if (enable && s_axis_tvalid) begin
            state   <= ST_HDR;
            pkt_len <= clamp_pkt_len(packetSize);
            cnt     <= '0;
          end
        end

        ST_HDR: begin
          if (reg_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hdr_rd_dat;
            m_axis_tlast  <= 1'b0;
            if (hdr_last) begin
              cnt <= '0;
`ifdef GBEMAC_PKT_SEQNUM_EN
              state <= ST_SEQ;
`else
              state <= ST_PAYLOAD;
`endif
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end

`ifdef GBEMAC_PKT_SEQNUM_EN
        ST_SEQ: begin
          if (reg_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= seq_num;
            m_axis_tlast  <= 1'b0;
            seq_num       <= seq_num + 32'd1;
            state         <= ST_PAYLOAD;
          end
        end
`endif

        ST_PAYLOAD: begin
          if (s_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= pay_last;
            if (pay_last) begin
              cnt        <= '0;
              state      <= ST_IDLE;
              frameCount <= frameCount + 32'd1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else if (reg_load) begin
            // Source bubble: the register empties instead of repeating a word.
            m_axis_tvalid <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gbemac_tx_packetizer.sv
// Self-checking bench for gbemac_tx_packetizer with a frame-level reference model.
// Latency: n/a.
// Backpressure: exercised via always-ready, 1-0-0-1 and random m_axis_tready patterns.
module tb_gbemac_tx_packetizer;

  localparam int HW = 11;
  localparam int AW = 4;
`ifdef GBEMAC_PKT_SEQNUM_EN
  localparam int SEQW = 1;
`else
  localparam int SEQW = 0;
`endif

  logic        Clk_user;
  logic        Reset;
  logic        enable;
  logic [15:0] packetSize;
  logic        hdrWrEn;
  logic [AW-1:0] hdrAddr;
  logic [31:0] hdrData;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;
  logic [31:0] frameCount;

  gbemac_tx_packetizer #(.HDR_WORDS(HW), .HDR_AW(AW)) dut (
    .Clk_user      (Clk_user),
    .Reset         (Reset),
    .enable        (enable),
    .packetSize    (packetSize),
    .hdrWrEn       (hdrWrEn),
    .hdrAddr       (hdrAddr),
    .hdrData       (hdrData),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frameCount    (frameCount)
  );

  initial Clk_user = 1'b0;
  always #5 Clk_user = ~Clk_user;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Source: samples src_arr[src_idx..src_end-1] are offered in order.
  logic [31:0] src_arr [4096];
  int src_idx = 0;
  int src_end = 0;
  int bubble_pct = 0;
  int rdy_mode = 0;
  int cyc = 0;

  // Reference model state.
  logic [31:0] hdr_m [HW];
  logic [31:0] seq_m = 0;
  logic [31:0] fc_m = 0;
  int mdl_idx = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int got_t[$];

  bit          stall_chk;
  bit          stall_held;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_l = 1'b0;
  bit          s_hs;

  task automatic drive_src();
    bit gap;
    gap = (bubble_pct > 0) && ($urandom_range(99) < bubble_pct);
    s_axis_tvalid = (src_idx < src_end) && !gap;
    s_axis_tdata  = src_arr[src_idx % 4096];
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_axis_tready = 1'($urandom_range(1));
    endcase
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic step();
    @(negedge Clk_user);
    stall_chk  = prev_stall;
    stall_held = m_axis_tvalid && (m_axis_tdata == prev_d) && (m_axis_tlast == prev_l);
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back({m_axis_tlast, m_axis_tdata});
      got_t.push_back(cyc);
    end
    s_hs       = s_axis_tvalid && s_axis_tready;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_d     = m_axis_tdata;
    prev_l     = m_axis_tlast;
    @(posedge Clk_user);
    #1;
    cyc++;
    if (s_hs) src_idx++;
    drive_src();
  endtask

  task automatic add_samples(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      src_arr[(src_end + i) % 4096] = rnd ? $urandom : 32'(src_end + i + 1);
    end
    src_end += n;
    drive_src();
  endtask

  // One frame as the spec describes it: header, optional sequence word, payload.
  task automatic add_frame(input int ps);
    int plen;
    plen = (ps == 0) ? 1 : ps;
    for (int i = 0; i < HW; i++) exp_q.push_back({1'b0, hdr_m[i]});
    if (SEQW == 1) begin
      exp_q.push_back({1'b0, seq_m});
      seq_m++;
    end
    for (int i = 0; i < plen; i++) begin
      exp_q.push_back({(i == plen - 1), src_arr[mdl_idx % 4096]});
      mdl_idx++;
    end
    fc_m++;
  endtask

  task automatic new_queues();
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) break;
      step();
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic write_hdr(input int a, input logic [31:0] d);
    hdrWrEn = 1'b1;
    hdrAddr = 4'(a);
    hdrData = d;
    step();
    hdrWrEn = 1'b0;
    if (a < HW) hdr_m[a] = d;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    enable = 1'b0;
    packetSize = 16'd4;
    hdrWrEn = 1'b0;
    hdrAddr = '0;
    hdrData = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge Clk_user);
    #1;
    Reset = 1'b0;
    step();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %08h want 0", m_axis_tdata); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %b want 0", s_axis_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frameCount !== 32'h0) begin errors++; $display("FAIL reset_frameCount got %0d want 0", frameCount); end
  endtask

  task automatic test_basic();
    bit ok;
    int fl;
    fl = HW + SEQW + 4;
    for (int i = 0; i < HW; i++) write_hdr(i, 32'hA0 + 32'(i));
    new_queues();
    rdy_mode = 0;
    bubble_pct = 0;
    packetSize = 16'd4;
    enable = 1'b1;
    add_samples(8, 1'b0);
    add_frame(4);
    add_frame(4);
    wait_words(exp_q.size(), 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_word[%0d] got last=%0b data=%08h want last=%0b data=%08h", i, got_q[i][32], got_q[i][31:0], exp_q[i][32], exp_q[i][31:0]);
      end
    end
    if (got_t.size() > fl) begin
      checks++; if (got_t[HW] - got_t[HW - 1] !== 1) begin errors++; $display("FAIL basic_hdr_to_next_gap got %0d want 1", got_t[HW] - got_t[HW - 1]); end
      checks++; if (got_t[fl] - got_t[fl - 1] !== 2) begin errors++; $display("FAIL basic_frame_gap got %0d want 2", got_t[fl] - got_t[fl - 1]); end
    end
    repeat (4) step();
    checks++; if (frameCount !== fc_m) begin errors++; $display("FAIL basic_frameCount got %0d want %0d", frameCount, fc_m); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_stall();
    int i;
    new_queues();
    rdy_mode = 1;
    packetSize = 16'd4;
    add_samples(8, 1'b1);
    add_frame(4);
    add_frame(4);
    for (i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) begin
      step();
      if (stall_chk) begin
        checks++;
        if (!stall_held) begin
          errors++;
          $display("FAIL stall_hold cycle %0d got vld=%b data=%08h last=%b want data=%08h last=%b", cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
        end
      end
    end
    checks++; if (got_q.size() < exp_q.size()) begin errors++; $display("FAIL stall_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL stall_word[%0d] got %09h want %09h", k, got_q[k], exp_q[k]);
      end
    end
    rdy_mode = 0;
    repeat (4) step();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_extra_words got %0d want %0d", got_q.size(), exp_q.size()); end
    checks++; if (frameCount !== fc_m) begin errors++; $display("FAIL stall_frameCount got %0d want %0d", frameCount, fc_m); end
  endtask

  task automatic test_size_change();
    bit ok;
    new_queues();
    packetSize = 16'd0;
    bubble_pct = 20;
    add_samples(3, 1'b1);
    for (int f = 0; f < 3; f++) add_frame(0);
    wait_words(exp_q.size(), 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL size0_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL size0_word[%0d] got %09h want %09h", i, got_q[i], exp_q[i]); end
    end
    repeat (4) step();
    bubble_pct = 0;
    new_queues();
    packetSize = 16'd4;
    add_samples(6, 1'b1);
    add_frame(4);
    add_frame(2);
    wait_words(1, 100, ok);
    packetSize = 16'd2;
    wait_words(exp_q.size(), 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sizechg_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sizechg_word[%0d] got %09h want %09h", i, got_q[i], exp_q[i]); end
    end
    repeat (4) step();
    checks++; if (frameCount !== fc_m) begin errors++; $display("FAIL sizechg_frameCount got %0d want %0d", frameCount, fc_m); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int rdy_seen;
    int i;
    new_queues();
    packetSize = 16'd4;
    enable = 1'b1;
    add_samples(8, 1'b1);
    add_frame(4);
    wait_words(4, 200, ok);
    enable = 1'b0;
    wait_words(exp_q.size(), 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (i = 0; i < 50 && busy; i++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got %b want 0", busy); end
    rdy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_axis_tready !== 1'b0) rdy_seen++;
    end
    checks++; if (rdy_seen != 0) begin errors++; $display("FAIL endrop_s_tready got %0d ready cycles want 0", rdy_seen); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL endrop_words got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL endrop_word[%0d] got %09h want %09h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (frameCount !== fc_m) begin errors++; $display("FAIL endrop_frameCount got %0d want %0d", frameCount, fc_m); end
    new_queues();
    add_frame(4);
    enable = 1'b1;
    wait_words(exp_q.size(), 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reenable_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL reenable_word[%0d] got %09h want %09h", k, got_q[k], exp_q[k]); end
    end
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    new_queues();
    packetSize = 16'd4;
    enable = 1'b1;
    add_samples(8, 1'b1);
    add_frame(4);
    wait_words(HW + SEQW + 2, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_payload got %0d words want %0d", got_q.size(), HW + SEQW + 2); end
    Reset = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (frameCount !== 32'h0) begin errors++; $display("FAIL rstmid_frameCount got %0d want 0", frameCount); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(posedge Clk_user);
    #1;
    Reset = 1'b0;
    prev_stall = 1'b0;
    new_queues();
    mdl_idx = src_idx;
    src_end = src_idx + 4;
    seq_m = 0;
    fc_m = 0;
    add_frame(4);
    drive_src();
    wait_words(exp_q.size(), 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rstmid_word[%0d] got %09h want %09h", k, got_q[k], exp_q[k]); end
    end
    repeat (4) step();
    checks++; if (frameCount !== fc_m) begin errors++; $display("FAIL rstmid_frameCount_after got %0d want %0d", frameCount, fc_m); end
  endtask

  task automatic test_random();
    bit ok;
    int ps;
    int nf;
    for (int it = 0; it < 4; it++) begin
      rdy_mode = 0;
      bubble_pct = 0;
      for (int i = 0; i < HW; i++) write_hdr(i, $urandom);
      write_hdr($urandom_range(15, HW), $urandom);
      new_queues();
      ps = $urandom_range(7, 1);
      nf = $urandom_range(3, 1);
      packetSize = 16'(ps);
      rdy_mode = 2;
      bubble_pct = 30;
      add_samples(ps * nf, 1'b1);
      for (int f = 0; f < nf; f++) add_frame(ps);
      wait_words(exp_q.size(), 3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got %0d words want %0d", it, got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_word[%0d] got %09h want %09h", it, k, got_q[k], exp_q[k]); end
      end
      rdy_mode = 0;
      repeat (6) step();
      checks++; if (frameCount !== fc_m) begin errors++; $display("FAIL rand%0d_frameCount got %0d want %0d", it, frameCount, fc_m); end
    end
    bubble_pct = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_size_change();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
